// File: rtl/digit_scan_ctrl.sv
// Scan controller for a multiplexed common-cathode seven-segment display.
// Rotates a one-hot digit select, blanks each slot start, suppresses leading zeros, commits loads at frame edges.
module digit_scan_ctrl #(
    parameter int DIGITS    = 3,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_N,
    input  logic                  enable,
    input  logic                  lz_suppress,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   number_BCD,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [4*DIGITS-1:0]   disp_val;
    logic [4*DIGITS-1:0]   pend_val;
    logic                  pending;

    logic [3:0]            cur_nib;
    logic                  lead_zero;
    logic                  zero_run;
    logic                  frame_end;
    logic [6:0]            seg_nxt;
    logic [DIGITS-1:0]     sel_nxt;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign load_ready = !pending;

    // Walk from the most significant nibble down so zero_run tells whether
    // every nibble above and including the active one is zero.
    always_comb begin
        cur_nib   = 4'h0;
        lead_zero = 1'b0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_val[i*4 +: 4] == 4'h0);
            if (dig_idx == IDX_W'(i)) begin
                cur_nib   = disp_val[i*4 +: 4];
                lead_zero = zero_run && (i != 0);
            end
        end

        sel_nxt = '0;
        seg_nxt = '0;
        if (slot_cnt >= BLANK_END) begin
            sel_nxt = DIGITS'(1) << dig_idx;
            seg_nxt = (lz_suppress && lead_zero) ? 7'h00 : decode(cur_nib);
        end

        frame_end = (slot_cnt == SLOT_LAST) && (dig_idx == IDX_LAST);
    end

    // Commit and accept are exclusive: accept needs pending low, commit needs it high.
    always_ff @(posedge clk) begin
        if (rst_N) begin
            slot_cnt   <= '0;
            dig_idx    <= '0;
            disp_val   <= '0;
            pend_val   <= '0;
            pending    <= 1'b0;
            seg_out    <= '0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load_valid && !pending) begin
                pend_val <= number_BCD;
                pending  <= 1'b1;
            end

            if (enable) begin
                if (slot_cnt == SLOT_LAST) begin
                    slot_cnt <= '0;
                    dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
                seg_out    <= seg_nxt;
                dig_sel    <= sel_nxt;
                frame_done <= frame_end;
                if (frame_end && pending) begin
                    disp_val <= pend_val;
                    pending  <= 1'b0;
                end
            end else begin
                slot_cnt   <= '0;
                dig_idx    <= '0;
                seg_out    <= '0;
                dig_sel    <= '0;
                frame_done <= 1'b0;
                if (pending) begin
                    disp_val <= pend_val;
                    pending  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: a frame-position reference model predicts each
// registered output cycle, and a separate monitor compares after every clock edge.
module tb_digit_scan_ctrl;

    localparam int D     = 3;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = D * DIV;

    logic            clk;
    logic            rst_N;
    logic            enable;
    logic            lz_suppress;
    logic            load_valid;
    logic            load_ready;
    logic [4*D-1:0]  number_BCD;
    logic [6:0]      seg_out;
    logic [D-1:0]    dig_sel;
    logic            frame_done;

    digit_scan_ctrl #(.DIGITS(D), .SCAN_DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk(clk),
        .rst_N(rst_N),
        .enable(enable),
        .lz_suppress(lz_suppress),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .number_BCD(number_BCD),
        .seg_out(seg_out),
        .dig_sel(dig_sel),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [6:0]   seg;
        logic [D-1:0] sel;
        logic         done;
        logic         ready;
    } exp_t;

    exp_t            exp_q[$];
    logic [4*D-1:0]  tx_q[$];

    int              n_checks = 0;
    int              n_pass   = 0;

    // Reference model state: position in the frame, shown value, held load.
    int              m_pos;
    logic [4*D-1:0]  m_shown;
    logic [4*D-1:0]  m_held;
    bit              m_has_held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int nib);
        logic [6:0] s;
        case (nib)
            0: s = 7'h3F;  1: s = 7'h06;  2: s = 7'h5B;  3: s = 7'h4F;
            4: s = 7'h66;  5: s = 7'h6D;  6: s = 7'h7D;  7: s = 7'h07;
            8: s = 7'h7F;  9: s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the coming edge and queue its prediction.
    task automatic applyStimulus(input bit rst, input bit en, input bit lz, input bit hold_off);
        logic            lv;
        logic [4*D-1:0]  num;
        exp_t            e;
        bit              was_held;
        int              slot;
        int              digit;
        int              upper;

        @(negedge clk);
        lv  = !hold_off && (tx_q.size() != 0);
        num = (tx_q.size() != 0) ? tx_q[0] : (4*D)'($urandom);
        rst_N       = rst;
        enable      = en;
        lz_suppress = lz;
        load_valid  = lv;
        number_BCD  = num;

        e = '0;
        if (rst) begin
            m_pos      = 0;
            m_shown    = '0;
            m_held     = '0;
            m_has_held = 0;
        end else begin
            was_held = m_has_held;
            if (en) begin
                slot  = m_pos % DIV;
                digit = m_pos / DIV;
                upper = int'(m_shown) >> (4 * digit);
                if (slot >= BLANK) begin
                    e.sel = D'(1 << digit);
                    e.seg = (lz && digit != 0 && upper == 0) ? 7'h00 : seg_of(upper % 16);
                end
                e.done = (m_pos == FRAME - 1);
                if (e.done && was_held) begin
                    m_shown    = m_held;
                    m_has_held = 0;
                end
                m_pos = (m_pos + 1) % FRAME;
            end else begin
                m_pos = 0;
                if (was_held) begin
                    m_shown    = m_held;
                    m_has_held = 0;
                end
            end
            if (lv && !was_held) begin
                m_held     = num;
                m_has_held = 1;
                void'(tx_q.pop_front());
            end
        end
        e.ready = !m_has_held;
        exp_q.push_back(e);
    endtask

    task automatic runCycles(input int n, input bit en, input bit lz);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, en, lz, 1'b0);
    endtask

    function automatic logic [4*D-1:0] randValue();
        logic [4*D-1:0] v;
        int             top;
        v   = '0;
        top = $urandom_range(0, D - 1);
        for (int i = 0; i <= top; i++) begin
            if ($urandom_range(0, 7) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else                           v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Monitor: every edge the DUT presents a fresh registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("seg_out",    32'(seg_out),    32'(e.seg));
                checkOutput("dig_sel",    32'(dig_sel),    32'(e.sel));
                checkOutput("frame_done", 32'(frame_done), 32'(e.done));
                checkOutput("load_ready", 32'(load_ready), 32'(e.ready));
            end
        end
    end

    initial begin
        bit lz_r;
        bit en_r;
        rst_N = 1'b1; enable = 1'b0; lz_suppress = 1'b0; load_valid = 1'b0; number_BCD = '0;
        m_pos = 0; m_shown = '0; m_held = '0; m_has_held = 0;

        $display("[TB] reset");
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] load 0x123");
        tx_q.push_back(12'h123);
        runCycles(60, 1'b1, 1'b1);

        $display("[TB] lz on/off with 0x007");
        tx_q.push_back(12'h007);
        runCycles(48, 1'b1, 1'b1);
        runCycles(48, 1'b1, 1'b0);

        $display("[TB] back-to-back 0x111 / 0x222");
        tx_q.push_back(12'h111);
        tx_q.push_back(12'h222);
        runCycles(80, 1'b1, 1'b1);

        $display("[TB] invalid BCD 0x0A0");
        tx_q.push_back(12'h0A0);
        runCycles(50, 1'b1, 1'b1);

        $display("[TB] enable drop with pending load");
        tx_q.push_back(12'h456);
        runCycles(5, 1'b1, 1'b1);
        runCycles(3, 1'b0, 1'b1);
        runCycles(40, 1'b1, 1'b1);

        $display("[TB] reset mid-slot with pending load");
        tx_q.push_back(12'h789);
        runCycles(3, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        runCycles(40, 1'b1, 1'b1);

        $display("[TB] random phase");
        lz_r = 1'b1;
        en_r = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if (tx_q.size() < 3 && $urandom_range(0, 19) == 0) tx_q.push_back(randValue());
            if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
            if (en_r) en_r = ($urandom_range(0, 99) != 0);
            else      en_r = ($urandom_range(0, 3) == 0);
            applyStimulus($urandom_range(0, 299) == 0, en_r, lz_r, $urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        #3;
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-cathode seven-segment display sharing one segment bus.
- Rotates a one-hot digit select and drives decoded segments for the active digit.
- Inserts an anti-ghosting blank interval at each slot start and applies leading-zero suppression.
- Accepts new BCD values via valid/ready, committed only at frame boundaries (tear-free).
- Sits between the counter/BCD datapath and the board display pins; replaces the parallel per-digit drive for scanned boards.

Parameters:
- DIGITS, 3, number of digits scanned (legal 1..8).
- SCAN_DIV, 50000, clock cycles per digit slot (legal ≥ 2).
- BLANK_CYC, 16, blank cycles at start of each slot (legal 0 ≤ BLANK_CYC < SCAN_DIV).

Ports:
- clk  in  1  system clock.
- rst_N  in  1  synchronous reset, active-high.
- enable  in  1  1 = scan running; 0 = display dark, counters held at 0.
- lz_suppress  in  1  1 = blank leading zero digits.
- load_valid  in  1  number_BCD is valid.
- load_ready  out  1  controller can accept a load.
- number_BCD  in  4*DIGITS  BCD value; nibble 0 = least significant digit.
- seg_out  out  7  segments {g,f,e,d,c,b,a}, 1 = lit.
- dig_sel  out  DIGITS  one-hot digit enable, 1 = on; bit i = digit i.
- frame_done  out  1  one-cycle pulse at end of the last digit slot.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst_N (port name retained, polarity fixed high).
- Reset values: slot_cnt=0, dig_idx=0, disp_val=0, pend_val=0, pending=0, seg_out=0, dig_sel=0, frame_done=0, load_ready=1.
  - Reset mid-frame aborts the frame and discards any pending load.
- Counters (enable=1):
  - slot_cnt increments 0..SCAN_DIV-1, then wraps to 0 and advances dig_idx.
  - dig_idx wraps DIGITS-1 → 0.
  - Frame = DIGITS slots.
- enable=0: slot_cnt and dig_idx are held at 0. A pending load is committed on the next clock. Registered outputs go to seg_out=0, dig_sel=0, frame_done=0.
- Handshake:
  - load_ready = !pending (combinational from register).
  - Transfer occurs when load_valid && load_ready: pend_val <= number_BCD, pending <= 1.
  - Commit: on the cycle where slot_cnt=SCAN_DIV-1 and dig_idx=DIGITS-1 (frame end), or the first enabled-low cycle. Effect: disp_val <= pend_val, pending <= 0.
  - load_ready returns to 1 the cycle after commit. No new transfer can occur in the commit cycle, since load_ready is 0 then.
  - A load held while load_ready=0 stalls; no data is dropped.
- Output generation: outputs are registered with 1-cycle latency; the values at cycle t+1 derive from state at cycle t.
  - slot_cnt < BLANK_CYC: dig_sel=0, seg_out=0.
  - Otherwise: dig_sel = 1<<dig_idx, seg_out = decode(disp_val nibble dig_idx).
- Decode table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Nibbles A–F decode to 40 (dash).
- Leading-zero suppression (lz_suppress=1):
  - Digit i is blanked (seg_out=0, dig_sel still asserted) if nibbles DIGITS-1..i of disp_val are all 0 and i ≠ 0.
  - Digit 0 is never suppressed.
  - A nonzero invalid nibble (A–F) stops suppression.
  - lz_suppress is sampled live each cycle.
- frame_done: registered pulse, high for exactly one cycle, in the cycle after the frame-end state (aligned with the commit becoming visible).
- Each frame lasts DIGITS*SCAN_DIV cycles. Digit duty = (SCAN_DIV-BLANK_CYC)/(DIGITS*SCAN_DIV).

Test Plan:
- Load 0x123 after reset, DIGITS=3, SCAN_DIV=8, BLANK_CYC=2, enable=1 -> handshake accepted at cycle 0.
  - First frame shows 000: dig0 seg 3F; dig1/dig2 dark with lz=1.
  - frame_done pulses at cycle 24; from then dig0=4F, dig1=5B, dig2=06.
  - Each slot: 2 cycles dig_sel=0, then 6 cycles one-hot.
- lz_suppress on 0x007 -> dig2 and dig1 have seg_out=00, dig0=07. With lz_suppress=0 -> dig2=3F, dig1=3F, dig0=07.
- Back-to-back loads 0x111 then 0x222, load_valid held continuously -> load_ready=0 until the first commit.
  - 0x111 is displayed for one full frame, then 0x222.
  - No value is skipped and the second transfer occurs the cycle after the commit.
- Invalid BCD 0x0A0, lz=1 -> dig2 blank, dig1=40, dig0=3F.
- enable dropped mid-frame with a pending load -> next cycle seg_out=0, dig_sel=0, load_ready=1.
  - On re-enable, the scan restarts at dig0, slot_cnt=0, showing the new value.
- rst_N=1 asserted mid-slot with pending=1 -> next cycle all outputs 0, load_ready=1, disp_val=0. Scan restarts at dig0 after release.
